spi_axis_slave: RTL and testbench
=================================

# spi_axis_slave

SPI responder (mode 0, CPOL=0/CPHA=0) bridging an external SPI master to the internal byte-wide AXIS fabric. It is the device-side counterpart of our SPI master: it oversamples `spi_csn`/`spi_clk`/`spi_mosi` in the system clock domain. Received MOSI bytes go out on an AXIS master port. Bytes taken from an AXIS slave port are shifted out on MISO. It sits behind the board SPI pins in test fixtures and chip emulation.

## Interface
- `MSB_FIRST`, 0: bit order on both MOSI and MISO; 0 = LSB first.
- `SYNC_STAGES`, 2: synchronizer depth for SPI inputs; legal 2..4.
- `IDLE_BYTE`, 8'h00: byte shifted on MISO when no TX byte is available.
- `clk` in 1: system clock; all logic on posedge.
- `rst` in 1: synchronous, active-high reset.
- `s_axis_tdata` in 8: TX byte for MISO.
- `s_axis_tvalid` in 1: TX byte valid.
- `s_axis_tready` out 1: registered; high when TX holding register empty.
- `m_axis_tdata` out 8: received MOSI byte.
- `m_axis_tvalid` out 1: received byte valid; held until accepted.
- `m_axis_tready` in 1: downstream accept.
- `spi_csn` in 1: async, active-low select.
- `spi_clk` in 1: async SPI clock.
- `spi_mosi` in 1: async data in.
- `spi_miso` out 1: TX shift register output bit.
- `spi_miso_oe` out 1: high while synchronized CSN low.
- `rx_overflow` out 1: one-cycle pulse, received byte dropped.
- `tx_underrun` out 1: one-cycle pulse, `IDLE_BYTE` substituted.

## Operation
- All three SPI inputs pass through identical `SYNC_STAGES`-deep flop chains; one further register holds the previous SCLK/CSN for edge detection.
  - `rise` = sync SCLK 1, previous 0.
  - `fall` = sync SCLK 0, previous 1.
  - `cs_start` = sync CSN 0, previous 1.
  - `cs_end` = sync CSN 1, previous 0.
- Edges are acted on only while sync CSN is low.
- States: IDLE (CSN high), SHIFT (CSN low).
  - IDLE->SHIFT on `cs_start`.
  - SHIFT->IDLE on `cs_end`.
- TX holding register, one byte: filled when `s_axis_tvalid && s_axis_tready`. `s_axis_tready` <= !hold_valid, updated every cycle.
- TX shift register load ("load event"): occurs on `cs_start`, and on the `fall` that follows a completed byte (bit counter wrapped to 0).
  - If hold_valid: load the holding byte and clear hold_valid.
  - Otherwise: load `IDLE_BYTE` and pulse `tx_underrun`.
  - Load and AXIS fill in the same cycle: load takes the old hold content; the new byte enters hold.
- `fall` with counter != 0: TX shift register shifts one bit (toward bit 0 if LSB first, toward bit 7 if MSB first).
- `spi_miso`: bit 0 of the TX shift register (LSB first) or bit 7 (MSB first).
- `rise`: shift sync MOSI into the RX shift register; 3-bit bit counter increments and wraps 7->0.
- `rise` with counter == 7 (byte complete):
  - If `m_axis_tvalid` is low, or `m_axis_tready` is high that cycle: `m_axis_tdata` <= assembled byte, `m_axis_tvalid` <= 1.
  - Otherwise: drop the byte and pulse `rx_overflow`; `m_axis_tdata` is unchanged.
- `m_axis_tvalid` clears on `m_axis_tvalid && m_axis_tready` unless a new byte lands in the same cycle.
- `cs_end` mid-byte:
  - Bit counter <= 0.
  - Partial RX bits discarded; no output, no overflow pulse.
  - TX shift content discarded; the holding register is kept.
- Reset values:
  - `s_axis_tready` 0, rising to 1 the first cycle after reset.
  - `m_axis_tvalid` 0, `m_axis_tdata` 0.
  - `spi_miso` 0, `spi_miso_oe` 0.
  - `rx_overflow` 0, `tx_underrun` 0.
  - Shift registers 0, counter 0, hold_valid 0, synchronizer chains 1 (CSN) / 0 (SCLK, MOSI).
- Reset asserted mid-transfer aborts the frame. After release the block waits for a fresh `cs_start`; a CSN already low is not treated as a start.

## Timing
- SCLK high and low phases must each be >= `SYNC_STAGES`+2 `clk` periods, i.e. f_sclk <= f_clk/(2*(SYNC_STAGES+2)); f_clk/8 minimum ratio at default.
- The host must leave >= `SYNC_STAGES`+2 `clk` periods between CSN fall and the first SCLK rise, so bit 0 of MISO is valid at that rise.
- MISO changes `SYNC_STAGES`+2 cycles after a pin-level SCLK fall: sync, edge register, shift register.
- RX latency: `m_axis_tvalid` rises `SYNC_STAGES`+2 cycles after the pin-level 8th SCLK rise.
- Loading TX bytes: the next byte must be in the holding register before the `fall` after the 8th `rise`, or underrun occurs.
- `rx_overflow` and `tx_underrun` are registered and exactly one cycle wide.

## Test plan
- Single frame, LSB first: hold 8'hA5 pre-loaded; master sends 8'h3C at f_clk/8 -> `m_axis_tdata`=8'h3C with one valid; master captures 8'hA5; no status pulses.
- Four-byte burst, `MSB_FIRST`=1: TX stream 01,02,03,04; master sends F0..F3 -> RX sequence F0,F1,F2,F3 in order; master reads 01..04; `s_axis_tready` rearms after each load.
- Underrun: no TX data, 2-byte frame -> master reads `IDLE_BYTE` twice; two `tx_underrun` pulses.
- Overflow: `m_axis_tready`=0, 3 bytes sent -> first byte held valid; bytes 2 and 3 dropped with two `rx_overflow` pulses; after ready, exactly one beat with byte 1.
- Abort: CSN raised after 5 bits, then a new full frame with 8'h81 -> no output for the partial byte; next output is 8'h81; MISO restarts from the next held byte.
- Reset mid-frame: `rst` pulsed during bit 3 while CSN stays low -> all outputs at reset values; nothing received until CSN toggles high then low.

Source files
------------

// File: rtl/spi_axis_slave.sv
// ============================================================================
// Module      : spi_axis_slave
// Description : SPI mode-0 responder bridging an external SPI master to the
//               byte-wide AXIS fabric. SPI pins are oversampled in the clk
//               domain. MOSI bytes leave on the AXIS master port; bytes taken
//               from the AXIS slave port are shifted out on MISO.
// Ports       : clk, rst              - system clock, sync active-high reset
//               s_axis_*              - TX bytes for MISO (one-byte holding reg)
//               m_axis_*              - received MOSI bytes
//               spi_csn/clk/mosi      - asynchronous SPI pins
//               spi_miso, spi_miso_oe - MISO data and output enable
//               rx_overflow           - pulse: received byte dropped
//               tx_underrun           - pulse: IDLE_BYTE substituted
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module spi_axis_slave #(
    parameter int         MSB_FIRST   = 0,
    parameter int         SYNC_STAGES = 2,
    parameter logic [7:0] IDLE_BYTE   = 8'h00
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] s_axis_tdata,
    input  logic       s_axis_tvalid,
    output logic       s_axis_tready,
    output logic [7:0] m_axis_tdata,
    output logic       m_axis_tvalid,
    input  logic       m_axis_tready,
    input  logic       spi_csn,
    input  logic       spi_clk,
    input  logic       spi_mosi,
    output logic       spi_miso,
    output logic       spi_miso_oe,
    output logic       rx_overflow,
    output logic       tx_underrun
);

    localparam logic [2:0] c_SETTLE_CNT = 3'(SYNC_STAGES);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    logic [SYNC_STAGES-1:0] r_csn_sync;
    logic [SYNC_STAGES-1:0] r_sclk_sync;
    logic [SYNC_STAGES-1:0] r_mosi_sync;
    logic                   r_csn_prev;
    logic                   r_sclk_prev;
    logic [2:0]             r_settle_cnt;
    logic                   r_armed;

    logic [7:0] r_rx_shift;
    logic [7:0] r_tx_shift;
    logic [2:0] r_bit_cnt;
    logic [7:0] r_hold_data;
    logic       r_hold_valid;
    logic       r_s_tready;
    logic [7:0] r_m_tdata;
    logic       r_m_tvalid;
    logic       r_miso_oe;
    logic       r_rx_overflow;
    logic       r_tx_underrun;

    logic       w_csn;
    logic       w_sclk;
    logic       w_mosi;
    logic       w_settled;
    logic       w_cs_start;
    logic       w_cs_end;
    logic       w_in_shift;
    logic       w_rise_act;
    logic       w_fall_act;
    logic       w_cs_end_act;
    logic       w_load;
    logic       w_fill;
    logic       w_hold_valid_nxt;
    logic       w_byte_done;
    logic [7:0] w_rx_next;
    logic [7:0] w_tx_shifted;

    assign w_csn  = r_csn_sync[SYNC_STAGES-1];
    assign w_sclk = r_sclk_sync[SYNC_STAGES-1];
    assign w_mosi = r_mosi_sync[SYNC_STAGES-1];

    // The CSN chain resets to "deselected"; until the pin value has reached
    // the chain output, a low CSN must not be mistaken for a fresh select.
    // r_armed additionally requires a genuine high CSN before any start, so a
    // frame already in progress across reset is ignored.
    assign w_settled  = (r_settle_cnt == c_SETTLE_CNT);
    assign w_cs_start = !w_csn && r_csn_prev && r_armed;
    assign w_cs_end   = w_csn && !r_csn_prev;

    assign w_in_shift   = (r_state == ST_SHIFT);
    assign w_rise_act   = w_in_shift && !w_csn && w_sclk && !r_sclk_prev;
    assign w_fall_act   = w_in_shift && !w_csn && !w_sclk && r_sclk_prev;
    assign w_cs_end_act = w_in_shift && w_cs_end;

    // Load at select, and at the first falling edge after a byte completes.
    assign w_load = w_cs_start || (w_fall_act && (r_bit_cnt == 3'd0));
    assign w_fill = s_axis_tvalid && r_s_tready;

    // A fill in the same cycle as a load wins: the load consumed the old content.
    assign w_hold_valid_nxt = w_fill ? 1'b1 : ((w_load && r_hold_valid) ? 1'b0 : r_hold_valid);

    assign w_byte_done = w_rise_act && (r_bit_cnt == 3'd7);

    assign w_rx_next    = (MSB_FIRST != 0) ? {r_rx_shift[6:0], w_mosi} : {w_mosi, r_rx_shift[7:1]};
    assign w_tx_shifted = (MSB_FIRST != 0) ? {r_tx_shift[6:0], 1'b0}   : {1'b0, r_tx_shift[7:1]};

    // ---------------- synchronizers and edge history ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_csn_sync   <= '1;
            r_sclk_sync  <= '0;
            r_mosi_sync  <= '0;
            r_csn_prev   <= 1'b1;
            r_sclk_prev  <= 1'b0;
            r_settle_cnt <= 3'd0;
            r_armed      <= 1'b0;
        end else begin
            r_csn_sync  <= {r_csn_sync[SYNC_STAGES-2:0], spi_csn};
            r_sclk_sync <= {r_sclk_sync[SYNC_STAGES-2:0], spi_clk};
            r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], spi_mosi};
            r_csn_prev  <= w_csn;
            r_sclk_prev <= w_sclk;
            if (!w_settled) begin
                r_settle_cnt <= r_settle_cnt + 3'd1;
            end
            if (w_settled && w_csn) begin
                r_armed <= 1'b1;
            end
        end
    end

    // ---------------- frame state machine ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:  if (w_cs_start) w_state_nxt = ST_SHIFT;
            ST_SHIFT: if (w_cs_end)   w_state_nxt = ST_IDLE;
            default:  w_state_nxt = ST_IDLE;
        endcase
    end

    // ---------------- datapath ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rx_shift    <= 8'h00;
            r_tx_shift    <= 8'h00;
            r_bit_cnt     <= 3'd0;
            r_hold_data   <= 8'h00;
            r_hold_valid  <= 1'b0;
            r_s_tready    <= 1'b0;
            r_m_tdata     <= 8'h00;
            r_m_tvalid    <= 1'b0;
            r_miso_oe     <= 1'b0;
            r_rx_overflow <= 1'b0;
            r_tx_underrun <= 1'b0;
        end else begin
            r_rx_overflow <= 1'b0;
            r_tx_underrun <= 1'b0;
            r_miso_oe     <= (w_state_nxt == ST_SHIFT);

            // Receive side: a deselect mid-byte throws the partial byte away.
            if (w_cs_end_act) begin
                r_bit_cnt  <= 3'd0;
                r_rx_shift <= 8'h00;
            end else if (w_rise_act) begin
                r_bit_cnt  <= r_bit_cnt + 3'd1;
                r_rx_shift <= w_rx_next;
            end

            // Transmit shifter; the holding register survives a deselect.
            if (w_cs_end_act) begin
                r_tx_shift <= 8'h00;
            end else if (w_load) begin
                if (r_hold_valid) begin
                    r_tx_shift <= r_hold_data;
                end else begin
                    r_tx_shift    <= IDLE_BYTE;
                    r_tx_underrun <= 1'b1;
                end
            end else if (w_fall_act) begin
                r_tx_shift <= w_tx_shifted;
            end

            if (w_fill) begin
                r_hold_data <= s_axis_tdata;
            end
            r_hold_valid <= w_hold_valid_nxt;
            // Derived from the next hold state so a full register never
            // advertises room for a second byte.
            r_s_tready   <= !w_hold_valid_nxt;

            if (w_byte_done && (!r_m_tvalid || m_axis_tready)) begin
                r_m_tdata  <= w_rx_next;
                r_m_tvalid <= 1'b1;
            end else if (w_byte_done) begin
                r_rx_overflow <= 1'b1;
            end else if (r_m_tvalid && m_axis_tready) begin
                r_m_tvalid <= 1'b0;
            end
        end
    end

    assign s_axis_tready = r_s_tready;
    assign m_axis_tdata  = r_m_tdata;
    assign m_axis_tvalid = r_m_tvalid;
    assign spi_miso      = (MSB_FIRST != 0) ? r_tx_shift[7] : r_tx_shift[0];
    assign spi_miso_oe   = r_miso_oe;
    assign rx_overflow   = r_rx_overflow;
    assign tx_underrun   = r_tx_underrun;

endmodule

`default_nettype wire

// File: tb/tb_spi_axis_slave.sv
// ============================================================================
// Module      : tb_spi_axis_slave
// Description : Self-checking bench for spi_axis_slave. Two instances share
//               the SPI pins: index 0 is LSB first with IDLE_BYTE 8'hD2,
//               index 1 is MSB first with the default IDLE_BYTE. Only the
//               instance selected by 'sel' is observed in each scenario.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_spi_axis_slave;

    localparam int         P     = 4;      // clk periods per SCLK phase (f_clk/8)
    localparam logic [7:0] IDLE0 = 8'hD2;
    localparam logic [7:0] IDLE1 = 8'h00;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic spi_csn  = 1'b1;
    logic spi_clk  = 1'b0;
    logic spi_mosi = 1'b0;

    logic [7:0] s_tdata  [2];
    logic       s_tvalid [2];
    logic       s_tready [2];
    logic [7:0] m_tdata  [2];
    logic       m_tvalid [2];
    logic       m_tready [2];
    logic       miso     [2];
    logic       miso_oe  [2];
    logic       ovf      [2];
    logic       und      [2];

    int total   = 0;
    int bad     = 0;
    int sel     = 0;
    int beats   = 0;
    int ovf_cnt = 0;
    int und_cnt = 0;

    logic [7:0] rx_q   [$];
    logic [7:0] miso_q [$];
    logic [7:0] rx_exp;
    logic [7:0] mosi_buf [8];
    logic [7:0] miso_buf [8];

    spi_axis_slave #(.MSB_FIRST(0), .SYNC_STAGES(2), .IDLE_BYTE(IDLE0)) u_dut_lsb (
        .clk(clk), .rst(rst),
        .s_axis_tdata(s_tdata[0]), .s_axis_tvalid(s_tvalid[0]), .s_axis_tready(s_tready[0]),
        .m_axis_tdata(m_tdata[0]), .m_axis_tvalid(m_tvalid[0]), .m_axis_tready(m_tready[0]),
        .spi_csn(spi_csn), .spi_clk(spi_clk), .spi_mosi(spi_mosi),
        .spi_miso(miso[0]), .spi_miso_oe(miso_oe[0]),
        .rx_overflow(ovf[0]), .tx_underrun(und[0])
    );

    spi_axis_slave #(.MSB_FIRST(1), .SYNC_STAGES(2), .IDLE_BYTE(IDLE1)) u_dut_msb (
        .clk(clk), .rst(rst),
        .s_axis_tdata(s_tdata[1]), .s_axis_tvalid(s_tvalid[1]), .s_axis_tready(s_tready[1]),
        .m_axis_tdata(m_tdata[1]), .m_axis_tvalid(m_tvalid[1]), .m_axis_tready(m_tready[1]),
        .spi_csn(spi_csn), .spi_clk(spi_clk), .spi_mosi(spi_mosi),
        .spi_miso(miso[1]), .spi_miso_oe(miso_oe[1]),
        .rx_overflow(ovf[1]), .tx_underrun(und[1])
    );

    // Scoreboard side of the RX path: every accepted beat pops one expectation.
    always @(negedge clk) begin
        if (!rst) begin
            if (m_tvalid[sel] && m_tready[sel]) begin
                beats++;
                total++;
                if (rx_q.size() == 0) begin
                    bad++;
                    $display("FAIL rx_beat: got %02h, required no beat", m_tdata[sel]);
                end else begin
                    rx_exp = rx_q.pop_front();
                    if (m_tdata[sel] !== rx_exp) begin
                        bad++;
                        $display("FAIL rx_data: got %02h, required %02h", m_tdata[sel], rx_exp);
                    end
                end
            end
            if (ovf[sel]) ovf_cnt++;
            if (und[sel]) und_cnt++;
        end
    end

    task automatic clks(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic apply_reset(input int s);
        sel = s;
        m_tready[0] = 1'b1;
        m_tready[1] = 1'b1;
        rst = 1'b1;
        clks(3);
        rst = 1'b0;
        clks(8);
        rx_q.delete();
        miso_q.delete();
        beats   = 0;
        ovf_cnt = 0;
        und_cnt = 0;
    endtask

    task automatic axis_send(input logic [7:0] b);
        int n;
        s_tdata[sel]  = b;
        s_tvalid[sel] = 1'b1;
        n = 0;
        while (s_tready[sel] !== 1'b1 && n < 500) begin
            clks(1);
            n++;
        end
        total++;
        if (n >= 500) begin
            bad++;
            $display("FAIL axis_send_timeout: tready=%b after %0d cycles, required 1", s_tready[sel], n);
        end
        clks(1);
        s_tvalid[sel] = 1'b0;
    endtask

    // Mode-0 master; the frame ends with CSN raised while SCLK is still high.
    task automatic spi_frame(input int n);
        logic [7:0] rb;
        spi_csn = 1'b0;
        clks(6);
        for (int k = 0; k < n; k++) begin
            rb = 8'h00;
            for (int i = 0; i < 8; i++) begin
                spi_clk  = 1'b0;
                spi_mosi = (sel != 0) ? mosi_buf[k][7-i] : mosi_buf[k][i];
                clks(P);
                if (sel != 0) rb[7-i] = miso[sel];
                else          rb[i]   = miso[sel];
                spi_clk = 1'b1;
                clks(P);
            end
            miso_buf[k] = rb;
        end
        spi_csn = 1'b1;
        clks(6);
        spi_clk = 1'b0;
        clks(6);
    endtask

    task automatic check_miso(input int n);
        logic [7:0] e;
        for (int k = 0; k < n; k++) begin
            e = miso_q.pop_front();
            total++;
            if (miso_buf[k] !== e) begin
                bad++;
                $display("FAIL miso_byte%0d: got %02h, required %02h", k, miso_buf[k], e);
            end
        end
    endtask

    task automatic check_int(input string name, input int got, input int req);
        total++;
        if (got !== req) begin
            bad++;
            $display("FAIL %s: got %0d, required %0d", name, got, req);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        clks(3);
        for (int d = 0; d < 2; d++) begin
            total++;
            if ({s_tready[d], m_tvalid[d], m_tdata[d], miso[d], miso_oe[d], ovf[d], und[d]} !== 14'h0) begin
                bad++;
                $display("FAIL reset_outputs%0d: got rdy=%b vld=%b data=%02h miso=%b oe=%b ovf=%b und=%b, required all 0",
                         d, s_tready[d], m_tvalid[d], m_tdata[d], miso[d], miso_oe[d], ovf[d], und[d]);
            end
        end
        rst = 1'b0;
        clks(1);
        for (int d = 0; d < 2; d++) begin
            total++;
            if (s_tready[d] !== 1'b1) begin
                bad++;
                $display("FAIL tready_after_reset%0d: got %b, required 1", d, s_tready[d]);
            end
        end
    endtask

    task automatic test_single();
        apply_reset(0);
        axis_send(8'hA5);
        mosi_buf[0] = 8'h3C;
        rx_q.push_back(8'h3C);
        miso_q.push_back(8'hA5);
        spi_frame(1);
        clks(10);
        check_miso(1);
        check_int("single_beats", beats, 1);
        check_int("single_ovf", ovf_cnt, 0);
        check_int("single_und", und_cnt, 0);
    endtask

    task automatic test_back_to_back();
        apply_reset(1);
        for (int k = 0; k < 4; k++) begin
            mosi_buf[k] = 8'hF0 + 8'(k);
            rx_q.push_back(8'hF0 + 8'(k));
            miso_q.push_back(8'h01 + 8'(k));
        end
        axis_send(8'h01);
        fork
            begin
                axis_send(8'h02);
                axis_send(8'h03);
                axis_send(8'h04);
            end
            begin
                spi_frame(4);
            end
        join
        clks(10);
        check_miso(4);
        check_int("burst_beats", beats, 4);
        check_int("burst_und", und_cnt, 0);
        check_int("burst_ovf", ovf_cnt, 0);
        check_int("burst_tready", int'(s_tready[1]), 1);
    endtask

    task automatic test_underrun();
        apply_reset(0);
        mosi_buf[0] = 8'h11;
        mosi_buf[1] = 8'h22;
        rx_q.push_back(8'h11);
        rx_q.push_back(8'h22);
        miso_q.push_back(IDLE0);
        miso_q.push_back(IDLE0);
        spi_frame(2);
        clks(10);
        check_miso(2);
        check_int("underrun_pulses", und_cnt, 2);
        check_int("underrun_beats", beats, 2);
    endtask

    task automatic test_overflow();
        apply_reset(0);
        m_tready[0] = 1'b0;
        mosi_buf[0] = 8'h5A;
        mosi_buf[1] = 8'h6B;
        mosi_buf[2] = 8'h7C;
        spi_frame(3);
        clks(4);
        check_int("ovf_held_valid", int'(m_tvalid[0]), 1);
        check_int("ovf_held_data", int'(m_tdata[0]), 32'h5A);
        check_int("ovf_pulses", ovf_cnt, 2);
        rx_q.push_back(8'h5A);
        m_tready[0] = 1'b1;
        clks(6);
        check_int("ovf_beats", beats, 1);
        check_int("ovf_valid_cleared", int'(m_tvalid[0]), 0);
    endtask

    task automatic test_abort();
        logic [7:0] rb;
        apply_reset(0);
        axis_send(8'h99);
        spi_csn = 1'b0;
        clks(6);
        axis_send(8'h4E);
        rb = 8'h00;
        for (int i = 0; i < 5; i++) begin
            spi_clk  = 1'b0;
            spi_mosi = 1'b1;
            clks(P);
            rb[i]   = miso[0];
            spi_clk = 1'b1;
            clks(P);
        end
        spi_csn = 1'b1;
        clks(6);
        spi_clk = 1'b0;
        clks(6);
        check_int("abort_partial_miso", int'(rb[4:0]), 32'h19);
        check_int("abort_no_beat", beats, 0);
        mosi_buf[0] = 8'h81;
        rx_q.push_back(8'h81);
        miso_q.push_back(8'h4E);
        spi_frame(1);
        clks(10);
        check_miso(1);
        check_int("abort_beats", beats, 1);
        check_int("abort_und", und_cnt, 0);
        check_int("abort_ovf", ovf_cnt, 0);
    endtask

    task automatic test_reset_mid_frame();
        apply_reset(0);
        axis_send(8'h33);
        spi_csn = 1'b0;
        clks(6);
        for (int i = 0; i < 2; i++) begin
            spi_clk  = 1'b0;
            spi_mosi = 1'b0;
            clks(P);
            spi_clk = 1'b1;
            clks(P);
        end
        spi_clk = 1'b0;
        clks(2);
        rst = 1'b1;
        clks(2);
        total++;
        if ({s_tready[0], m_tvalid[0], miso[0], miso_oe[0], ovf[0], und[0]} !== 6'h0) begin
            bad++;
            $display("FAIL midreset_outputs: got rdy=%b vld=%b miso=%b oe=%b ovf=%b und=%b, required all 0",
                     s_tready[0], m_tvalid[0], miso[0], miso_oe[0], ovf[0], und[0]);
        end
        rst = 1'b0;
        clks(2);
        // CSN never left low: these edges must be ignored.
        for (int i = 0; i < 8; i++) begin
            spi_mosi = 1'b1;
            spi_clk  = 1'b1;
            clks(P);
            spi_clk = 1'b0;
            clks(P);
        end
        clks(6);
        check_int("midreset_no_beat", beats, 0);
        check_int("midreset_oe_low", int'(miso_oe[0]), 0);
        spi_csn = 1'b1;
        clks(8);
        mosi_buf[0] = 8'h6D;
        rx_q.push_back(8'h6D);
        miso_q.push_back(IDLE0);
        spi_frame(1);
        clks(10);
        check_miso(1);
        check_int("midreset_beats", beats, 1);
        check_int("midreset_und", und_cnt, 1);
    endtask

    initial begin
        for (int d = 0; d < 2; d++) begin
            s_tdata[d]  = 8'h00;
            s_tvalid[d] = 1'b0;
            m_tready[d] = 1'b1;
        end
        test_reset();
        test_single();
        test_back_to_back();
        test_underrun();
        test_overflow();
        test_abort();
        test_reset_mid_frame();
        total++;
        if (rx_q.size() != 0) begin
            bad++;
            $display("FAIL rx_leftover: got %0d pending, required 0", rx_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
